// File: rtl/wum_window_buffer.sv
// Circular packet byte buffer that presents a SIGN_DEPTH-byte sliding window
// to the Wu-Manber matcher and advances it by the shift amount the FSM loads.
`timescale 1ns/1ps
module wum_window_buffer #(
  parameter int SIGN_DEPTH = 5,
  parameter int BUF_AW     = 6,
  parameter int SFT_WDH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic                    input_ready,
  input  logic                    shift_amt_ld,
  input  logic [SFT_WDH-1:0]      shift_amt,
  output logic                    datInReady,
  output logic [8*SIGN_DEPTH-1:0] window,
  output logic [SIGN_DEPTH-1:0]   win_mask,
  output logic [15:0]             byte_offset,
  output logic                    pkt_done
);

  localparam int DEPTH = 1 << BUF_AW;
  localparam int CNT_W = BUF_AW + 1;

  typedef enum logic [1:0] {FILL, AVAIL, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [BUF_AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_next;
  logic [CNT_W-1:0]  adv, adv_eff, wr_ext;
  logic              last_seen;
  logic              wr_en, load_now, shift_now, drained;
  int unsigned       adv_req;

  // count can never exceed DEPTH, so its top bit alone means "full"
  assign in_ready  = ~count[BUF_AW] & ~last_seen;
  assign wr_en     = in_valid & in_ready;
  assign load_now  = (state_q == AVAIL) & input_ready;
  assign shift_now = (state_q == LOCKED) & shift_amt_ld;

  // A zero shift still moves one byte so the scan always makes progress
  always_comb begin
    adv_req    = (shift_amt == '0) ? 32'd1 : 32'(shift_amt);
    adv        = (adv_req > 32'(count)) ? count : CNT_W'(adv_req);
    adv_eff    = shift_now ? adv : '0;
    wr_ext     = CNT_W'(wr_en);
    count_next = count + wr_ext - adv_eff;
    drained    = shift_now & last_seen & (count_next == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (count >= CNT_W'(SIGN_DEPTH) || (last_seen && count != '0)) begin
          state_d = AVAIL;
        end
      end
      AVAIL: begin
        if (input_ready) begin
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (shift_amt_ld) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    datInReady = (state_q == AVAIL);
  end

  // Storage is not reset; a reset simply abandons whatever the pointers covered
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_seen   <= 1'b0;
      window      <= '0;
      win_mask    <= '0;
      byte_offset <= '0;
      pkt_done    <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + BUF_AW'(1);
      end
      if (shift_now) begin
        rd_ptr <= rd_ptr + adv[BUF_AW-1:0];
      end
      count    <= count_next;
      pkt_done <= drained;
      if (drained) begin
        last_seen <= 1'b0;
      end else if (wr_en && in_last) begin
        last_seen <= 1'b1;
      end
      if (drained) begin
        byte_offset <= '0;
      end else if (shift_now) begin
        byte_offset <= byte_offset + 16'(adv);
      end
      // Bytes past the packet tail are zero-filled and masked off
      if (load_now) begin
        for (int i = 0; i < SIGN_DEPTH; i++) begin
          if (CNT_W'(i) < count) begin
            window[8*i +: 8] <= mem[rd_ptr + BUF_AW'(i)];
            win_mask[i]      <= 1'b1;
          end else begin
            window[8*i +: 8] <= 8'h00;
            win_mask[i]      <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wum_window_buffer.sv
// Directed bench for wum_window_buffer: a queue-based packet model is checked
// against the DUT every cycle, plus literal expectations from worked examples.
`timescale 1ns/1ps
module tb_wum_window_buffer;

  localparam int SD    = 5;
  localparam int AW    = 6;
  localparam int SW    = 4;
  localparam int DEPTH = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_last = 1'b0;
  logic            in_ready;
  logic            input_ready = 1'b0;
  logic            shift_amt_ld = 1'b0;
  logic [SW-1:0]   shift_amt = '0;
  logic            datInReady;
  logic [8*SD-1:0] window;
  logic [SD-1:0]   win_mask;
  logic [15:0]     byte_offset;
  logic            pkt_done;

  int n_compared = 0;
  int n_mismatched = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  wum_window_buffer #(.SIGN_DEPTH(SD), .BUF_AW(AW), .SFT_WDH(SW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .input_ready(input_ready),
    .shift_amt_ld(shift_amt_ld), .shift_amt(shift_amt), .datInReady(datInReady),
    .window(window), .win_mask(win_mask), .byte_offset(byte_offset),
    .pkt_done(pkt_done)
  );

  // Model: the buffered bytes are a queue, the window is its head
  byte unsigned    q[$];
  bit              m_last;
  int              m_phase;
  logic [8*SD-1:0] m_win;
  logic [SD-1:0]   m_mask;
  logic [15:0]     m_off;
  bit              m_done;
  int              m_n, m_adv;
  bit              m_wr, m_drained;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_last = 0; m_phase = 0; m_win = '0; m_mask = '0; m_off = '0; m_done = 0;
    end else begin
      m_n = q.size();
      m_wr = in_valid && (m_n < DEPTH) && !m_last;
      m_drained = 0;
      case (m_phase)
        0: if (m_n >= SD || (m_last && m_n > 0)) m_phase = 1;
        1: if (input_ready) begin
             m_win = '0; m_mask = '0;
             for (int i = 0; i < SD && i < m_n; i++) begin
               m_win[8*i +: 8] = q[i];
               m_mask[i] = 1'b1;
             end
             m_phase = 2;
           end
        default: if (shift_amt_ld) begin
             m_adv = (shift_amt == 0) ? 1 : int'(shift_amt);
             if (m_adv > m_n) m_adv = m_n;
             repeat (m_adv) void'(q.pop_front());
             m_off = m_off + 16'(m_adv);
             m_phase = 0;
             if (m_last && q.size() == 0) m_drained = 1;
           end
      endcase
      if (m_drained) begin
        m_last = 0;
        m_off = '0;
      end
      if (m_wr) begin
        q.push_back(in_data);
        if (in_last) m_last = 1;
      end
      m_done = m_drained;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("in_ready", in_ready, (q.size() < DEPTH) && !m_last);
    check("datInReady", datInReady, m_phase == 1);
    check("window", window, m_win);
    check("win_mask", win_mask, m_mask);
    check("byte_offset", byte_offset, m_off);
    check("pkt_done", pkt_done, m_done);
  endtask

  always @(negedge clk) if (chk_en) checkOutput();

  task automatic applyStimulus(input logic [7:0] first, input int n, input bit last_flag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = first + 8'(i);
      in_last  = last_flag && (i == n - 1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pulse_load();
    int k = 0;
    while (!datInReady && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("avail_wait", datInReady, 1'b1);
    input_ready = 1'b1;
    @(negedge clk);
    input_ready = 1'b0;
  endtask

  task automatic pulse_shift(input int a);
    shift_amt    = SW'(a);
    shift_amt_ld = 1'b1;
    @(negedge clk);
    shift_amt_ld = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_datInReady", datInReady, 1'b0);

    // Eight bytes, first window, then shift by 3
    applyStimulus(8'h10, 8, 1'b0);
    pulse_load();
    check("s1_window", window, 40'h14_13_12_11_10);
    check("s1_mask", win_mask, 5'b11111);
    check("s1_offset", byte_offset, 16'd0);
    pulse_shift(3);
    pulse_load();
    check("s2_window", window, 40'h17_16_15_14_13);
    check("s2_offset", byte_offset, 16'd3);
    check("s2_model_count", q.size(), 5);

    // Seven-byte packet with tail padding and saturated advance
    do_reset();
    applyStimulus(8'hA0, 7, 1'b1);
    pulse_load();
    check("s3_window_a", window, 40'hA4_A3_A2_A1_A0);
    pulse_shift(5);
    pulse_load();
    check("s3_window_b", window, 40'h00_00_00_A6_A5);
    check("s3_mask_b", win_mask, 5'b00011);
    pulse_shift(4);
    check("s3_pkt_done", pkt_done, 1'b1);
    check("s3_offset", byte_offset, 16'd0);
    check("s3_in_ready", in_ready, 1'b1);
    @(negedge clk);
    check("s3_pkt_done_low", pkt_done, 1'b0);

    // Zero shift still advances one byte
    do_reset();
    applyStimulus(8'h30, 6, 1'b0);
    pulse_load();
    pulse_shift(0);
    pulse_load();
    check("s4_offset", byte_offset, 16'd1);
    check("s4_window", window, 40'h35_34_33_32_31);

    // Full buffer, then pointer wrap with concurrent writes and shifts
    do_reset();
    applyStimulus(8'h00, 70, 1'b0);
    check("s5_full_in_ready", in_ready, 1'b0);
    check("s5_model_count", q.size(), 64);
    fork
      begin
        for (int i = 0; i < 160; i++) begin
          @(negedge clk);
          in_valid = 1'b1;
          in_data  = 8'(i * 7 + 3);
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        for (int r = 0; r < 10; r++) begin
          pulse_load();
          pulse_shift(15);
        end
      end
    join

    // Reset while LOCKED with 20 bytes buffered, then a fresh packet
    do_reset();
    applyStimulus(8'h60, 20, 1'b0);
    pulse_load();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("s6_in_ready", in_ready, 1'b1);
    check("s6_datInReady", datInReady, 1'b0);
    check("s6_window", window, 40'h0);
    check("s6_mask", win_mask, 5'b00000);
    check("s6_offset", byte_offset, 16'd0);
    check("s6_pkt_done", pkt_done, 1'b0);
    applyStimulus(8'h50, 6, 1'b1);
    pulse_load();
    check("s6_window_a", window, 40'h54_53_52_51_50);
    pulse_shift(5);
    pulse_load();
    check("s6_window_b", window, 40'h00_00_00_00_55);
    check("s6_mask_b", win_mask, 5'b00001);
    pulse_shift(1);
    check("s6_pkt_done_b", pkt_done, 1'b1);
    @(negedge clk);
    chk_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
